// File: rtl/rsa_modexp_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rsa_modexp_ctrl_pkg : shared types and defaults for the modexp    |
// | sequencer.                                                        |
// | Rev 1.0                                                           |
// +--------------------------------------------------------------------+
package rsa_modexp_ctrl_pkg;

  localparam int RSA_WIDTH  = 512;
  localparam int RSA_ELEN_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TOMONT   = 3'd1,
    ST_SQUARE   = 3'd2,
    ST_MULT     = 3'd3,
    ST_NEXT     = 3'd4,
    ST_FROMMONT = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  // States that launch one Montgomery multiplication on entry.
  function automatic logic is_issue(input state_t s);
    return (s == ST_TOMONT) || (s == ST_SQUARE) || (s == ST_MULT) || (s == ST_FROMMONT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rsa_modexp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rsa_modexp_ctrl : left-to-right square-and-multiply x^e mod m,    |
// | driving an external Montgomery core over a start/done handshake.  |
// | Rev 1.0                                                           |
// +--------------------------------------------------------------------+
module rsa_modexp_ctrl
  import rsa_modexp_ctrl_pkg::*;
#(
  parameter int WIDTH  = RSA_WIDTH,
  parameter int ELEN_W = RSA_ELEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  in_x,
  input  logic [WIDTH-1:0]  in_e,
  input  logic [ELEN_W-1:0] in_elen,
  input  logic [WIDTH-1:0]  in_m,
  input  logic [WIDTH-1:0]  in_rmodm,
  input  logic [WIDTH-1:0]  in_r2modm,
  output logic [WIDTH-1:0]  result,
  output logic              done,
  output logic              busy,
  output logic              mm_start,
  output logic [WIDTH-1:0]  mm_a,
  output logic [WIDTH-1:0]  mm_b,
  output logic [WIDTH-1:0]  mm_m,
  input  logic [WIDTH-1:0]  mm_result,
  input  logic              mm_done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    e_q, e_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    xm_q, xm_d;
  logic [ELEN_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                mm_start_q, mm_start_d;
  logic [WIDTH-1:0]    mm_a_q, mm_a_d;
  logic [WIDTH-1:0]    mm_b_q, mm_b_d;
  logic [WIDTH-1:0]    mm_m_q, mm_m_d;

  logic [ELEN_W-1:0]   w_elen_clamped;
  logic                w_ack;
  logic                w_ebit;

  assign w_elen_clamped = (32'(in_elen) > WIDTH) ? ELEN_W'(WIDTH) : in_elen;
  // A done coincident with our own start pulse cannot belong to this request.
  assign w_ack          = mm_done & ~mm_start_q;
  assign w_ebit         = |(e_q & (ONE << idx_q));

  always_comb begin
    state_d  = state_q;
    e_d      = e_q;
    a_d      = a_q;
    xm_d     = xm_q;
    idx_d    = idx_q;
    result_d = result_q;
    mm_a_d   = mm_a_q;
    mm_b_d   = mm_b_q;
    mm_m_d   = mm_m_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // x and R^2 mod m live in the operand registers for the first multiply.
          e_d     = in_e;
          idx_d   = w_elen_clamped;
          a_d     = in_rmodm;
          mm_a_d  = in_x;
          mm_b_d  = in_r2modm;
          mm_m_d  = in_m;
          state_d = ST_TOMONT;
        end
      end
      ST_TOMONT: begin
        if (w_ack) begin
          xm_d = mm_result;
          if (idx_q == '0) begin
            state_d = ST_FROMMONT;
          end else begin
            idx_d   = idx_q - ELEN_W'(1);
            state_d = ST_SQUARE;
          end
        end
      end
      ST_SQUARE: begin
        if (w_ack) begin
          a_d     = mm_result;
          state_d = w_ebit ? ST_MULT : ST_NEXT;
        end
      end
      ST_MULT: begin
        if (w_ack) begin
          a_d     = mm_result;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (idx_q == '0) begin
          state_d = ST_FROMMONT;
        end else begin
          idx_d   = idx_q - ELEN_W'(1);
          state_d = ST_SQUARE;
        end
      end
      ST_FROMMONT: begin
        if (w_ack) begin
          result_d = mm_result;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Operands are loaded on the edge that enters an issuing state.
    mm_start_d = is_issue(state_d) && (state_d != state_q);
    if (mm_start_d) begin
      case (state_d)
        ST_SQUARE: begin
          mm_a_d = a_d;
          mm_b_d = a_d;
        end
        ST_MULT: begin
          mm_a_d = a_d;
          mm_b_d = xm_d;
        end
        ST_FROMMONT: begin
          mm_a_d = a_d;
          mm_b_d = ONE;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      e_q        <= '0;
      a_q        <= '0;
      xm_q       <= '0;
      idx_q      <= '0;
      result_q   <= '0;
      mm_start_q <= 1'b0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_m_q     <= '0;
    end else begin
      state_q    <= state_d;
      e_q        <= e_d;
      a_q        <= a_d;
      xm_q       <= xm_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      mm_start_q <= mm_start_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      mm_m_q     <= mm_m_d;
    end
  end

  assign result   = result_q;
  assign done     = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE);
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_m     = mm_m_q;

endmodule
`default_nettype wire
